program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_pkg.sv | 24 ++
 rtl/loader_timeout.sv | 37 +++
 rtl/program_loader.sv | 155 +++++++++++++++
 tb/tb_program_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and frame constants for the serial program loader.
// The frame carries multi-byte fields low byte first.
package program_loader_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CNT_LO  = 3'd1,
        CNT_HI  = 3'd2,
        DATA_LO = 3'd3,
        DATA_HI = 3'd4,
        CHECK   = 3'd5
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Bit position of each byte inside a reassembled 16-bit field.
    localparam int LO_SHIFT = 0;
    localparam int HI_SHIFT = 8;

    function automatic logic [15:0] join_halfword(input logic [7:0] hi, input logic [7:0] lo);
        return (16'(hi) << HI_SHIFT) | (16'(lo) << LO_SHIFT);
    endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte watchdog: asserts expired on the cycle that completes
// TIMEOUT_CYCLES consecutive enabled cycles without a kick.
module loader_timeout #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic kick,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expired = enable && !kick && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (kick || !enable) begin
            cnt_d = '0;
        end else if (!expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Receives a framed byte stream and writes its halfwords into CPU program
// memory, verifying an XOR checksum and guarding against stalled frames.
module program_loader #(
    parameter logic [31:0] BASE_INDEX     = 32'd0,
    parameter int          MAX_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        download_program,
    output logic [31:0] instruction_index,
    output logic [15:0] program_in,
    output logic        busy,
    output logic        load_done,
    output logic        load_error
);

    import program_loader_pkg::*;

    state_e      state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [15:0] hw_cnt_q, hw_cnt_d;
    logic [7:0]  lo_byte_q, lo_byte_d;
    logic [7:0]  chk_q, chk_d;
    logic        dl_q, dl_d;
    logic [31:0] index_q, index_d;
    logic [15:0] prog_q, prog_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        timed_out;
    logic [15:0] count_full;
    logic        count_too_big;
    logic        last_hw;

    assign count_full    = join_halfword(rx_data, count_q[7:0]);
    assign count_too_big = {16'h0000, count_full} > 32'(MAX_WORDS);
    assign last_hw       = (hw_cnt_q + 16'd1) == count_q;

    loader_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q != IDLE),
        .kick   (rx_valid),
        .expired(timed_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            hw_cnt_q  <= '0;
            lo_byte_q <= '0;
            chk_q     <= '0;
            dl_q      <= 1'b0;
            index_q   <= '0;
            prog_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            hw_cnt_q  <= hw_cnt_d;
            lo_byte_q <= lo_byte_d;
            chk_q     <= chk_d;
            dl_q      <= dl_d;
            index_q   <= index_d;
            prog_q    <= prog_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (timed_out) begin
            state_d = IDLE;
        end else if (rx_valid) begin
            case (state_q)
                IDLE:    if (rx_data == SYNC_BYTE) state_d = CNT_LO;
                CNT_LO:  state_d = CNT_HI;
                CNT_HI: begin
                    if (count_too_big)           state_d = IDLE;
                    else if (count_full == 16'd0) state_d = CHECK;
                    else                          state_d = DATA_LO;
                end
                DATA_LO: state_d = DATA_HI;
                DATA_HI: state_d = last_hw ? CHECK : DATA_LO;
                CHECK:   state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath and pulses; program_in/instruction_index hold between writes so
    // the CPU's repeated writes of the same halfword are harmless.
    always_comb begin
        count_d   = count_q;
        hw_cnt_d  = hw_cnt_q;
        lo_byte_d = lo_byte_q;
        chk_d     = chk_q;
        dl_d      = dl_q;
        index_d   = index_q;
        prog_d    = prog_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        if (timed_out) begin
            err_d = 1'b1;
            dl_d  = 1'b0;
        end else if (rx_valid) begin
            case (state_q)
                IDLE: chk_d = '0;
                CNT_LO: begin
                    count_d = {8'h00, rx_data};
                    chk_d   = chk_q ^ rx_data;
                end
                CNT_HI: begin
                    count_d  = count_full;
                    hw_cnt_d = '0;
                    chk_d    = chk_q ^ rx_data;
                    err_d    = count_too_big;
                end
                DATA_LO: begin
                    lo_byte_d = rx_data;
                    chk_d     = chk_q ^ rx_data;
                end
                DATA_HI: begin
                    prog_d   = join_halfword(rx_data, lo_byte_q);
                    index_d  = BASE_INDEX + {16'h0000, hw_cnt_q};
                    dl_d     = 1'b1;
                    hw_cnt_d = hw_cnt_q + 16'd1;
                    chk_d    = chk_q ^ rx_data;
                end
                CHECK: begin
                    dl_d   = 1'b0;
                    done_d = (rx_data == chk_q);
                    err_d  = (rx_data != chk_q);
                end
                default: chk_d = '0;
            endcase
        end
    end

    assign busy              = (state_q != IDLE);
    assign download_program  = dl_q;
    assign instruction_index = index_q;
    assign program_in        = prog_q;
    assign load_done         = done_q;
    assign load_error        = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed and randomized frames checked against a position-based frame model.
module tb_program_loader;

    localparam logic [31:0] BASE_IDX = 32'd10;
    localparam int          MAX_W    = 1024;
    localparam int          TMO      = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        download_program;
    logic [31:0] instruction_index;
    logic [15:0] program_in;
    logic        busy;
    logic        load_done;
    logic        load_error;

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] fr[$];

    program_loader #(
        .BASE_INDEX    (BASE_IDX),
        .MAX_WORDS     (MAX_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .rx_valid         (rx_valid),
        .rx_data          (rx_data),
        .download_program (download_program),
        .instruction_index(instruction_index),
        .program_in       (program_in),
        .busy             (busy),
        .load_done        (load_done),
        .load_error       (load_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic eb, input logic edl,
                             input logic edone, input logic eerr,
                             input logic [31:0] eidx, input logic [15:0] eprog);
        chk({tag, " busy"}, 32'(busy), 32'(eb));
        chk({tag, " download_program"}, 32'(download_program), 32'(edl));
        chk({tag, " load_done"}, 32'(load_done), 32'(edone));
        chk({tag, " load_error"}, 32'(load_error), 32'(eerr));
        if (edl) begin
            chk({tag, " instruction_index"}, instruction_index, eidx);
            chk({tag, " program_in"}, 32'(program_in), 32'(eprog));
        end
    endtask

    task automatic cycle(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle_check(input string tag);
        cycle(1'b0, 8'h00);
        check_all(tag, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
    endtask

    // Sends fr[0..nsend-1]; expectations come from each byte's position in the frame.
    task automatic run_frame(input string tag, input int nsend, input int gapmax);
        int n, term, g;
        logic [7:0] x;
        logic good, e_busy, e_dl, e_done, e_err;
        logic [31:0] e_idx;
        logic [15:0] e_prog;
        n    = int'({fr[2], fr[1]});
        term = (n > MAX_W) ? 2 : 3 + 2 * n;
        x    = 8'h00;
        for (int i = 1; i < term; i++) x ^= fr[i];
        good   = (n <= MAX_W) && (fr[term] == x);
        e_busy = 1'b0;
        e_dl   = 1'b0;
        e_idx  = 32'd0;
        e_prog = 16'd0;
        for (int p = 0; p < nsend; p++) begin
            g = int'($urandom_range(gapmax, 0));
            repeat (g) begin
                cycle(1'b0, 8'h00);
                check_all({tag, " gap"}, e_busy, e_dl, 1'b0, 1'b0, e_idx, e_prog);
            end
            cycle(1'b1, fr[p]);
            e_done = (p == term) && good;
            e_err  = (p == term) && !good;
            e_busy = (p < term);
            e_dl   = (n > 0) && (n <= MAX_W) && (p >= 4) && (p < term);
            if (e_dl && (p % 2 == 0)) begin
                e_idx  = BASE_IDX + 32'((p - 4) / 2);
                e_prog = {fr[p], fr[p - 1]};
            end
            check_all(tag, e_busy, e_dl, e_done, e_err, e_idx, e_prog);
        end
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        chk("reset instruction_index", instruction_index, 32'd0);
        chk("reset program_in", 32'(program_in), 32'd0);
        reset = 1'b0;

        fr = {8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F, 8'hFA};
        run_frame("normal", 8, 0);
        chk("normal last index", instruction_index, 32'd11);
        chk("normal last data", 32'(program_in), 32'h1FC2);
        idle_check("normal idle");

        fr[7] = 8'h00;
        run_frame("bad checksum", 8, 2);
        idle_check("bad checksum idle");

        cycle(1'b1, 8'h3C);
        check_all("garbage 3C", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        cycle(1'b1, 8'h00);
        check_all("garbage 00", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        fr = {8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame("empty frame", 4, 0);
        idle_check("empty frame idle");

        fr = {8'hA5, 8'h01, 8'h00, 8'h05, 8'h00, 8'h00};
        run_frame("timeout frame", 4, 0);
        for (int i = 1; i <= TMO; i++) begin
            cycle(1'b0, 8'h00);
            check_all("timeout", (i < TMO), 1'b0, 1'b0, (i == TMO), 32'd0, 16'd0);
        end
        idle_check("after timeout");

        fr = {8'hA5, 8'h01, 8'h04};
        run_frame("oversize count", 3, 0);
        idle_check("oversize idle");

        fr = {8'hA5, 8'h02, 8'h00, 8'h05, 8'h20, 8'hC2, 8'h1F, 8'hFA};
        run_frame("pre-reset", 4, 0);
        reset    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h20;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        reset    = 1'b0;
        check_all("mid-frame reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
        chk("mid-frame reset instruction_index", instruction_index, 32'd0);
        chk("mid-frame reset program_in", 32'(program_in), 32'd0);
        idle_check("post-reset idle");
        run_frame("reload", 8, 1);
        idle_check("reload idle");

        for (int f = 0; f < 30; f++) begin
            logic [15:0] n;
            logic [7:0]  x, b;
            int          nn, ngarb;
            ngarb = int'($urandom_range(2, 0));
            repeat (ngarb) begin
                b = 8'($urandom_range(255, 0));
                if (b == 8'hA5) b = 8'h5A;
                cycle(1'b1, b);
                check_all("random garbage", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0);
            end
            n  = (f % 10 == 9) ? 16'(1025 + $urandom_range(500, 0)) : 16'($urandom_range(6, 0));
            nn = int'(n);
            fr.delete();
            fr.push_back(8'hA5);
            fr.push_back(n[7:0]);
            fr.push_back(n[15:8]);
            x = n[7:0] ^ n[15:8];
            if (nn <= MAX_W) begin
                for (int k = 0; k < 2 * nn; k++) begin
                    b = ($urandom_range(3, 0) == 0) ? 8'hA5 : 8'($urandom_range(255, 0));
                    fr.push_back(b);
                    x ^= b;
                end
                if ($urandom_range(3, 0) == 0) x ^= 8'($urandom_range(255, 1));
                fr.push_back(x);
            end
            run_frame("random", fr.size(), 4);
            idle_check("random idle");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
